heap_engine: RTL and testbench

//  Parametrised hardware binary-heap priority queue. Replaces the firmware heap loop with a

---
 rtl/heap_pkg.sv | 27 ++
 rtl/heap_cmp.sv | 14 +
 rtl/heap_engine.sv | 194 +++++++++++++++++++
 tb/tb_heap_engine.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/heap_pkg.sv
// Shared definitions for the heap priority-queue engine: command encodings,
// sift FSM states and the counter/index width helpers.
package heap_pkg;

    typedef enum logic [1:0] {
        OP_PUSH    = 2'b00,
        OP_POP     = 2'b01,
        OP_REPLACE = 2'b10,
        OP_CLEAR   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SIFT_UP,
        S_SIFT_DOWN
    } state_e;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // One extra bit so that 2*i+1 never wraps for any live index.
    function automatic int idx_w(input int depth);
        return $clog2(depth + 1) + 1;
    endfunction

endpackage

// File: rtl/heap_cmp.sv
// Heap ordering predicate: better(a,b) is a<b for a min-heap, a>b for a max-heap.
// Equal keys are never "better", so ties never cause a swap.
module heap_cmp #(
    parameter int DATA_W   = 8,
    parameter int MIN_HEAP = 1
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              better
);

    assign better = (MIN_HEAP != 0) ? (a < b) : (a > b);

endmodule

// File: rtl/heap_engine.sv
// Binary-heap priority queue: register array mem[1..DEPTH] maintained by a
// sift-up / sift-down FSM. Ops: push, pop, replace, clear.
module heap_engine
    import heap_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int MIN_HEAP = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_op,
    input  logic [DATA_W-1:0]       cmd_data,
    output logic                    rsp_done,
    output logic                    rsp_err,
    output logic [DATA_W-1:0]       rsp_data,
    output logic [DATA_W-1:0]       top,
    output logic [cnt_w(DEPTH)-1:0] size,
    output logic                    empty,
    output logic                    full
);

    localparam int CW = cnt_w(DEPTH);
    localparam int IW = idx_w(DEPTH);

    state_e            state;
    logic [IW-1:0]     idx;
    logic [DATA_W-1:0] mem [1:DEPTH];

    logic [IW-1:0]     par_i, lft_i, rgt_i, best_i, cnt_x;
    logic [DATA_W-1:0] cur_k, par_k, lft_k, rgt_k, best_k, last_k;
    logic              up_better, rgt_better, dn_better, lft_ok, rgt_ok;
    logic              accept, up_swap, dn_swap;
    logic              wa_en, wb_en;
    logic [IW-1:0]     wa_i, wb_i;
    logic [DATA_W-1:0] wa_d, wb_d;

    assign cmd_ready = (state == S_IDLE);
    assign empty     = (size == '0);
    assign full      = (size == CW'(DEPTH));
    assign top       = empty ? '0 : mem[1];

    assign cnt_x  = IW'(size);
    assign par_i  = idx >> 1;
    assign lft_i  = idx << 1;
    assign rgt_i  = lft_i + IW'(1);
    assign lft_ok = (lft_i <= cnt_x);
    assign rgt_ok = (rgt_i <= cnt_x);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        cur_k  = '0;
        par_k  = '0;
        lft_k  = '0;
        rgt_k  = '0;
        last_k = '0;
        for (int i = 1; i <= DEPTH; i++) begin
            if (idx == IW'(i))   cur_k  = mem[i];
            if (par_i == IW'(i)) par_k  = mem[i];
            if (lft_i == IW'(i)) lft_k  = mem[i];
            if (rgt_i == IW'(i)) rgt_k  = mem[i];
            if (size == CW'(i))  last_k = mem[i];
        end
    end

    heap_cmp #(.DATA_W(DATA_W), .MIN_HEAP(MIN_HEAP)) u_cmp_up (
        .a(cur_k), .b(par_k), .better(up_better)
    );

    // Right child wins only when strictly better, so the left child is kept on ties.
    heap_cmp #(.DATA_W(DATA_W), .MIN_HEAP(MIN_HEAP)) u_cmp_kid (
        .a(rgt_k), .b(lft_k), .better(rgt_better)
    );

    assign best_i = (rgt_ok && rgt_better) ? rgt_i : lft_i;
    assign best_k = (rgt_ok && rgt_better) ? rgt_k : lft_k;

    heap_cmp #(.DATA_W(DATA_W), .MIN_HEAP(MIN_HEAP)) u_cmp_dn (
        .a(best_k), .b(cur_k), .better(dn_better)
    );

    assign accept  = cmd_valid && (state == S_IDLE);
    assign up_swap = (state == S_SIFT_UP) && (idx > IW'(1)) && up_better;
    assign dn_swap = (state == S_SIFT_DOWN) && lft_ok && dn_better;

    // Two write ports: port a for command loads and one half of a swap, port b for the other half.
    always_comb begin
        wa_en = 1'b0;
        wa_i  = '0;
        wa_d  = '0;
        wb_en = 1'b0;
        wb_i  = '0;
        wb_d  = '0;
        if (accept) begin
            case (op_e'(cmd_op))
                OP_PUSH:    if (!full)  begin wa_en = 1'b1; wa_i = cnt_x + IW'(1); wa_d = cmd_data; end
                OP_POP:     if (!empty) begin wa_en = 1'b1; wa_i = IW'(1);         wa_d = last_k;   end
                OP_REPLACE: if (!empty) begin wa_en = 1'b1; wa_i = IW'(1);         wa_d = cmd_data; end
                default: ;
            endcase
        end else if (up_swap) begin
            wa_en = 1'b1; wa_i = idx;   wa_d = par_k;
            wb_en = 1'b1; wb_i = par_i; wb_d = cur_k;
        end else if (dn_swap) begin
            wa_en = 1'b1; wa_i = idx;    wa_d = best_k;
            wb_en = 1'b1; wb_i = best_i; wb_d = cur_k;
        end
    end

    // NOTE: the key array is deliberately not reset; size alone decides which entries are live.
    always_ff @(posedge clk) begin
        for (int i = 1; i <= DEPTH; i++) begin
            if (wa_en && wa_i == IW'(i))      mem[i] <= wa_d;
            else if (wb_en && wb_i == IW'(i)) mem[i] <= wb_d;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            size     <= '0;
            idx      <= '0;
            rsp_done <= 1'b0;
            rsp_err  <= 1'b0;
            rsp_data <= '0;
        end else begin
            rsp_done <= 1'b0;
            rsp_err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        case (op_e'(cmd_op))
                            OP_PUSH: begin
                                if (full) begin
                                    rsp_done <= 1'b1;
                                    rsp_err  <= 1'b1;
                                end else begin
                                    size  <= size + CW'(1);
                                    idx   <= cnt_x + IW'(1);
                                    state <= S_SIFT_UP;
                                end
                            end
                            OP_POP: begin
                                if (empty) begin
                                    rsp_done <= 1'b1;
                                    rsp_err  <= 1'b1;
                                end else begin
                                    rsp_data <= mem[1];
                                    size     <= size - CW'(1);
                                    idx      <= IW'(1);
                                    if (size == CW'(1)) rsp_done <= 1'b1;
                                    else                state    <= S_SIFT_DOWN;
                                end
                            end
                            OP_REPLACE: begin
                                if (empty) begin
                                    rsp_done <= 1'b1;
                                    rsp_err  <= 1'b1;
                                end else begin
                                    rsp_data <= mem[1];
                                    idx      <= IW'(1);
                                    state    <= S_SIFT_DOWN;
                                end
                            end
                            default: begin
                                size     <= '0;
                                rsp_done <= 1'b1;
                            end
                        endcase
                    end
                end
                S_SIFT_UP: begin
                    if (up_swap) idx <= par_i;
                    else begin
                        state    <= S_IDLE;
                        rsp_done <= 1'b1;
                    end
                end
                S_SIFT_DOWN: begin
                    if (dn_swap) idx <= best_i;
                    else begin
                        state    <= S_IDLE;
                        rsp_done <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_heap_engine.sv
// Directed bench for heap_engine: a min-heap and a max-heap instance, each checked
// against a sorted reference model through an expected-response queue.
module tb_heap_engine;
    import heap_pkg::*;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int SW    = $clog2(DEPTH + 1);
    localparam int LAT   = 5;  // floor(log2 8) + 2

    logic          clk      = 1'b0;
    logic          reset    = 1'b0;
    logic [1:0]    valid    = '0;
    logic [1:0]    cmd_op   = '0;
    logic [DW-1:0] cmd_data = '0;
    logic [1:0]    ready, done, err, empty, full;
    logic [DW-1:0] rdata [2];
    logic [DW-1:0] top   [2];
    logic [SW-1:0] size  [2];

    always #5 clk = ~clk;

    heap_engine #(.DATA_W(DW), .DEPTH(DEPTH), .MIN_HEAP(1)) u_min (
        .clk(clk), .reset(reset), .cmd_valid(valid[0]), .cmd_ready(ready[0]),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .rsp_done(done[0]), .rsp_err(err[0]),
        .rsp_data(rdata[0]), .top(top[0]), .size(size[0]), .empty(empty[0]), .full(full[0])
    );

    heap_engine #(.DATA_W(DW), .DEPTH(DEPTH), .MIN_HEAP(0)) u_max (
        .clk(clk), .reset(reset), .cmd_valid(valid[1]), .cmd_ready(ready[1]),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .rsp_done(done[1]), .rsp_err(err[1]),
        .rsp_data(rdata[1]), .top(top[1]), .size(size[1]), .empty(empty[1]), .full(full[1])
    );

    typedef struct {
        int            w;
        logic          err;
        logic [DW-1:0] data;
        int            size;
        logic [DW-1:0] top;
        int            max_lat;
    } exp_t;

    exp_t          sb [$];
    int            mdl [2][$];
    logic [DW-1:0] last_data [2];
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Keeps the model sorted best-first: ascending for the min heap, descending for the max heap.
    task automatic m_insert(input int w, input int d);
        int p = 0;
        while (p < mdl[w].size() && ((w == 0) ? (mdl[w][p] <= d) : (mdl[w][p] >= d))) p++;
        mdl[w].insert(p, d);
    endtask

    task automatic issue(input int w, input op_e op, input logic [DW-1:0] d);
        exp_t e;
        int   n = 0;
        while (ready[w] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (ready[w] !== 1'b1) chk("ready_timeout", {31'b0, ready[w]}, 32'd1);
        e.w       = w;
        e.err     = 1'b0;
        e.data    = last_data[w];
        e.max_lat = 1;
        case (op)
            OP_PUSH: begin
                if (mdl[w].size() == DEPTH) e.err = 1'b1;
                else begin
                    m_insert(w, int'(d));
                    e.max_lat = LAT;
                end
            end
            OP_POP: begin
                if (mdl[w].size() == 0) e.err = 1'b1;
                else begin
                    e.data = DW'(mdl[w][0]);
                    mdl[w].delete(0);
                    e.max_lat = (mdl[w].size() == 0) ? 1 : LAT;
                end
            end
            OP_REPLACE: begin
                if (mdl[w].size() == 0) e.err = 1'b1;
                else begin
                    e.data = DW'(mdl[w][0]);
                    mdl[w].delete(0);
                    m_insert(w, int'(d));
                    e.max_lat = LAT;
                end
            end
            default: mdl[w].delete();
        endcase
        last_data[w] = e.data;
        e.size = mdl[w].size();
        e.top  = (e.size == 0) ? '0 : DW'(mdl[w][0]);
        sb.push_back(e);
        cmd_op   = op;
        cmd_data = d;
        valid[w] = 1'b1;
        @(negedge clk);
        valid[w] = 1'b0;
    endtask

    task automatic wait_done();
        exp_t e;
        int   lat = 1;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        while (done[e.w] !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("rsp_done", {31'b0, done[e.w]}, 32'd1);
        chk("latency",  {31'b0, (lat <= e.max_lat)}, 32'd1);
        chk("rsp_err",  {31'b0, err[e.w]}, {31'b0, e.err});
        chk("rsp_data", 32'(rdata[e.w]), 32'(e.data));
        chk("size",     32'(size[e.w]), 32'(e.size));
        chk("top",      32'(top[e.w]), 32'(e.top));
        chk("empty",    {31'b0, empty[e.w]}, {31'b0, (e.size == 0)});
        chk("full",     {31'b0, full[e.w]}, {31'b0, (e.size == DEPTH)});
        chk("cmd_ready", {31'b0, ready[e.w]}, 32'd1);
    endtask

    task automatic op(input int w, input op_e o, input logic [DW-1:0] d);
        issue(w, o, d);
        wait_done();
    endtask

    initial begin
        int seen;
        last_data[0] = '0;
        last_data[1] = '0;

        // Reset state, then POP on an empty heap.
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("reset_ready", {31'b0, ready[0]}, 32'd1);
        chk("reset_size",  32'(size[0]), 32'd0);
        chk("reset_top",   32'(top[0]), 32'd0);
        chk("reset_empty", {31'b0, empty[0]}, 32'd1);
        chk("reset_done",  {31'b0, done[0]}, 32'd0);
        chk("reset_data",  32'(rdata[0]), 32'd0);
        op(0, OP_POP, 8'h00);

        // Small push/pop.
        op(0, OP_PUSH, 8'h07);
        op(0, OP_PUSH, 8'h04);
        op(0, OP_POP, 8'h00);
        op(0, OP_CLEAR, 8'h00);

        // Fill in worst-case order, overflow, then drain ascending.
        for (int k = 8; k >= 1; k--) op(0, OP_PUSH, DW'(k));
        op(0, OP_PUSH, 8'h55);
        for (int k = 0; k < 8; k++) op(0, OP_POP, 8'h00);

        // Max heap: ascending pushes force full sift-up, drain descending.
        for (int k = 1; k <= 8; k++) op(1, OP_PUSH, DW'(k));
        op(1, OP_PUSH, 8'h66);
        for (int k = 0; k < 8; k++) op(1, OP_POP, 8'h00);
        op(1, OP_POP, 8'h00);

        // Pseudo-random keys with duplicates, mixed with replaces.
        for (int k = 0; k < 6; k++) op(0, OP_PUSH, DW'($urandom_range(0, 15)));
        for (int k = 0; k < 4; k++) op(0, OP_REPLACE, DW'($urandom_range(0, 15)));
        for (int k = 0; k < 6; k++) op(0, OP_POP, 8'h00);
        op(0, OP_REPLACE, 8'h11);

        // Replace on a three-entry heap, then clear.
        op(0, OP_PUSH, 8'h09);
        op(0, OP_PUSH, 8'h05);
        op(0, OP_PUSH, 8'h03);
        op(0, OP_REPLACE, 8'h0A);
        op(0, OP_CLEAR, 8'h00);

        // Reset while sifting down: op aborted, no completion.
        for (int k = 6; k >= 1; k--) op(0, OP_PUSH, DW'(k * 3));
        issue(0, OP_POP, 8'h00);
        void'(sb.pop_back());
        chk("busy_before_reset", {31'b0, ready[0]}, 32'd0);
        reset = 1'b0;
        #1;
        chk("abort_ready", {31'b0, ready[0]}, 32'd1);
        chk("abort_size",  32'(size[0]), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        mdl[0].delete();
        mdl[1].delete();
        last_data[0] = '0;
        last_data[1] = '0;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (done[0] !== 1'b0) seen++;
        end
        chk("abort_no_done", 32'(seen), 32'd0);
        chk("abort_top", 32'(top[0]), 32'd0);
        op(0, OP_PUSH, 8'h2A);
        op(0, OP_POP, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
